// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu -- load/store unit between a core request port and a single-port-
// per-direction synchronous RAM of 2^ADDR_BIT 32-bit words.
//
// Handles byte, halfword and word accesses. Loads are extracted from the read
// word and zero- or sign-extended. Sub-word stores are read-modify-write.
// Misaligned or illegal-size requests are answered with an error response and
// never touch the RAM. Only one request is in flight at a time.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   req_valid_i/ready_o  request handshake (ready only while idle)
//   req_we_i             1 = store, 0 = load
//   req_addr_i           byte address; word index = addr[ADDR_BIT+1:2]
//   req_size_i           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i       load extension: 1 = zero, 0 = sign
//   req_wdata_i          store data, right-aligned
//   rsp_valid_o          one-cycle response pulse
//   rsp_rdata_o          load result (0 for stores/errors), held between responses
//   rsp_err_o            misaligned / illegal-size flag, held between responses
//   ram_wen_o/waddr_o/wdata_o   RAM write port
//   ram_ren_o/raddr_o           RAM read port
//   ram_rdata_i                 RAM read data, valid the cycle after ram_ren_o
// -----------------------------------------------------------------------------
module dmem_lsu #(
    parameter int ADDR_BIT = 12
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [31:0]         req_addr_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  logic [31:0]         req_wdata_i,

    output logic                rsp_valid_o,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_err_o,

    output logic                ram_wen_o,
    output logic [ADDR_BIT-1:0] ram_waddr_o,
    output logic [31:0]         ram_wdata_o,
    output logic                ram_ren_o,
    output logic [ADDR_BIT-1:0] ram_raddr_o,
    input  logic [31:0]         ram_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_MERGE,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    state_e                state_q, state_d;

    // Latched request fields
    logic                  we_q;
    size_e                 size_q;
    logic                  uns_q;
    logic [1:0]            lane_q;
    logic [ADDR_BIT-1:0]   idx_q;
    logic [31:0]           wdata_q;

    // Response registers, updated only on the edge that enters RESP
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  req_bad;
    logic [31:0]           load_data;
    logic [31:0]           store_merged;

    // Address bits above the RAM window are deliberately ignored.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[31:ADDR_BIT+2];

    assign accept = req_valid_i && req_ready_o;

    // Misalignment / illegal size, decided from the live request in IDLE.
    always_comb begin
        unique case (size_e'(req_size_i))
            SZ_BYTE: req_bad = 1'b0;
            SZ_HALF: req_bad = req_addr_i[0];
            SZ_WORD: req_bad = (req_addr_i[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Lane extraction and extension of the returned RAM word.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel  = ram_rdata_i[{lane_q, 3'b000} +: 8];
        half_sel  = lane_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
        load_data = ram_rdata_i;
        case (size_q)
            SZ_BYTE: load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_data = ram_rdata_i;
        endcase
    end

    // Read-modify-write: old word with only the addressed lane replaced.
    always_comb begin
        store_merged = ram_rdata_i;
        if (size_q == SZ_BYTE) begin
            store_merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            store_merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        ram_wen_o   = 1'b0;
        ram_waddr_o = '0;
        ram_wdata_o = '0;
        ram_ren_o   = 1'b0;
        ram_raddr_o = '0;

        unique case (state_q)
            S_IDLE: begin
                // Ready is also held low while reset is asserted.
                req_ready_o = !rst;
                if (req_valid_i && !rst) begin
                    if (req_bad) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end

            S_ACCESS: begin
                if (we_q && size_q == SZ_WORD) begin
                    // Full-word store needs no read; write and respond.
                    ram_wen_o   = 1'b1;
                    ram_waddr_o = idx_q;
                    ram_wdata_o = wdata_q;
                    err_d       = 1'b0;
                    rdata_d     = '0;
                    state_d     = S_RESP;
                end else begin
                    ram_ren_o   = 1'b1;
                    ram_raddr_o = idx_q;
                    state_d     = S_MERGE;
                end
            end

            S_MERGE: begin
                err_d = 1'b0;
                if (we_q) begin
                    ram_wen_o   = 1'b1;
                    ram_waddr_o = idx_q;
                    ram_wdata_o = store_merged;
                    rdata_d     = '0;
                end else begin
                    rdata_d     = load_data;
                end
                state_d = S_RESP;
            end

            S_RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of block evaluation order.
        if (rst) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            lane_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we_i;
                size_q  <= size_e'(req_size_i);
                uns_q   <= req_unsigned_i;
                lane_q  <= req_addr_i[1:0];
                idx_q   <= req_addr_i[ADDR_BIT+1:2];
                wdata_q <= req_wdata_i;
            end
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu -- self-checking bench for dmem_lsu.
// A behavioural RAM sits on the DUT's RAM ports; a separate request-level
// reference memory predicts every response from the access rules directly.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    localparam int AB = 4;
    localparam int NW = 1 << AB;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic          req_uns;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_wen;
    logic [AB-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic          ram_ren;
    logic [AB-1:0] ram_raddr;
    logic [31:0]   ram_rdata;

    logic [31:0]   ram     [NW];
    logic [31:0]   ref_mem [NW];

    int n_tests = 0;
    int n_fail  = 0;
    int both_cnt = 0;
    int wen_cnt  = 0;
    int ren_cnt  = 0;
    int rsp_cnt  = 0;

    logic          rec_wen   [10];
    logic [AB-1:0] rec_waddr [10];
    logic [31:0]   rec_wdata [10];
    logic          rec_ren   [10];
    logic [AB-1:0] rec_raddr [10];

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_BIT(AB)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .ram_wen_o      (ram_wen),
        .ram_waddr_o    (ram_waddr),
        .ram_wdata_o    (ram_wdata),
        .ram_ren_o      (ram_ren),
        .ram_raddr_o    (ram_raddr),
        .ram_rdata_i    (ram_rdata)
    );

    // Behavioural synchronous RAM
    always @(posedge clk) begin
        if (ram_wen) ram[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= ram[ram_raddr];
    end

    // Activity monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (ram_wen && ram_ren) both_cnt++;
        if (ram_wen) wen_cnt++;
        if (ram_ren) ren_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % NW);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] w, v;
        int sh;
        w = ref_mem[widx(a)];
        if (sz == 2'd2) return w;
        if (sz == 2'd0) begin
            sh = int'(a % 4) * 8;
            v  = (w >> sh) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else begin
            sh = int'((a % 4) / 2) * 16;
            v  = (w >> sh) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        sh   = (sz == 2'd0) ? int'(a % 4) * 8 : (sz == 2'd1) ? int'((a % 4) / 2) * 16 : 0;
        ref_mem[widx(a)] = (ref_mem[widx(a)] & ~(mask << sh)) | ((wd & mask) << sh);
    endtask

    // ---------------- one request, fully checked ----------------
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd, input string tag);
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          lat;
        exp_err = ref_err(addr, sz);
        if (exp_err) begin
            exp_data = '0;
            exp_lat  = 1;
        end else if (we) begin
            exp_data = '0;
            exp_lat  = (sz == 2'd2) ? 2 : 3;
            ref_store(addr, sz, wd);
        end else begin
            exp_data = ref_load(addr, sz, uns);
            exp_lat  = 3;
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = sz;
        req_uns   = uns;
        req_wdata = wd;
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request fields: the DUT must use what it latched.
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        req_uns   = 1'($urandom_range(0, 1));
        req_wdata = $urandom;

        lat = 1;
        while (lat <= 8) begin
            rec_wen[lat]   = ram_wen;
            rec_waddr[lat] = ram_waddr;
            rec_wdata[lat] = ram_wdata;
            rec_ren[lat]   = ram_ren;
            rec_raddr[lat] = ram_raddr;
            if (rsp_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (lat <= 8) begin
            check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
            check({tag, " rdata"}, rsp_rdata, exp_data);
            @(posedge clk);
            #1;
            check({tag, " pulse"}, 32'(rsp_valid), 32'd0);
            check({tag, " hold"}, rsp_rdata, exp_data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w0, r0, s0;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] exp1, exp2;

        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_uns   = 1'b0;
        req_wdata = '0;

        // Reset state
        #1;
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rdata", rsp_rdata, 32'd0);
        check("rst err", 32'(rsp_err), 32'd0);
        check("rst wen", 32'(ram_wen), 32'd0);
        check("rst ren", 32'(ram_ren), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst ready", 32'(req_ready), 32'd1);

        // Word store to 0x10
        do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, "st_w");
        check("st_w wen", 32'(rec_wen[1]), 32'd1);
        check("st_w waddr", 32'(rec_waddr[1]), 32'd4);
        check("st_w wdata", rec_wdata[1], 32'hDEADBEEF);
        check("st_w no ren", 32'(rec_ren[1]), 32'd0);

        // Byte loads from 0x13, signed and unsigned
        do_req(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, "ld_bs");
        check("ld_bs value", rsp_rdata, 32'hFFFFFFDE);
        do_req(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, "ld_bu");
        check("ld_bu value", rsp_rdata, 32'h000000DE);

        // Halfword read-modify-write at 0x12
        do_req(1'b1, 32'h12, 2'd1, 1'b0, 32'h00001234, "st_h");
        check("st_h ren", 32'(rec_ren[1]), 32'd1);
        check("st_h raddr", 32'(rec_raddr[1]), 32'd4);
        check("st_h wen", 32'(rec_wen[2]), 32'd1);
        check("st_h wdata", rec_wdata[2], 32'h1234BEEF);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, "ld_w");
        check("ld_w value", rsp_rdata, 32'h1234BEEF);

        // Error requests never touch the RAM
        w0 = wen_cnt;
        r0 = ren_cnt;
        do_req(1'b0, 32'h11, 2'd2, 1'b0, 32'h0, "err_mis");
        check("err_mis flag", 32'(rsp_err), 32'd1);
        do_req(1'b1, 32'h10, 2'd3, 1'b0, 32'hFFFF_FFFF, "err_size");
        check("err_size flag", 32'(rsp_err), 32'd1);
        check("err no wen", 32'(wen_cnt - w0), 32'd0);
        check("err no ren", 32'(ren_cnt - r0), 32'd0);

        // Two loads with valid held high
        exp1 = ref_load(32'h11, 2'd0, 1'b1);
        exp2 = ref_load(32'h12, 2'd1, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h11;
        req_size  = 2'd0;
        req_uns   = 1'b1;
        @(posedge clk);
        #1;
        req_addr  = 32'h12;
        req_size  = 2'd1;
        req_uns   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("b2b ready k%0d", k), 32'(req_ready), 32'((k == 4) || (k == 8)));
            check($sformatf("b2b valid k%0d", k), 32'(rsp_valid), 32'((k == 3) || (k == 7)));
            if (k == 3) check("b2b rdata1", rsp_rdata, exp1);
            if (k == 7) check("b2b rdata2", rsp_rdata, exp2);
            if (k == 5) req_valid = 1'b0;
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a byte store
        do_req(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, "pre_rst_err");
        w0 = wen_cnt;
        s0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_size  = 2'd0;
        req_wdata = 32'h000000AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("abort in access", 32'(ram_ren), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort ready", 32'(req_ready), 32'd0);
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort err", 32'(rsp_err), 32'd0);
        check("abort rdata", rsp_rdata, 32'd0);
        check("abort wen", 32'(ram_wen), 32'd0);
        check("abort ren", 32'(ram_ren), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort ready after", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("abort no write", 32'(wen_cnt - w0), 32'd0);
        check("abort no rsp", 32'(rsp_cnt - s0), 32'd0);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, "abort mem");
        check("abort mem value", rsp_rdata, 32'h1234BEEF);

        // Random traffic against the reference model
        for (int i = 0; i < NW; i++) do_req(1'b1, 32'(i * 4), 2'd2, 1'b0, $urandom, "preload");
        for (int n = 0; n < 200; n++) begin
            a  = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
                   $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        for (int i = 0; i < NW; i++) check($sformatf("mem%0d", i), ram[i], ref_mem[i]);
        check("wen&ren never together", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter ADDR_BIT, default 12, sets the RAM word-address width; the RAM is 2^ADDR_BIT words of 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  input  1  core request valid.
REQ-005 req_ready_o  output  1  block can accept a request this cycle.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_addr_i  input  32  byte address; word index = req_addr_i[ADDR_BIT+1:2], higher bits ignored.
REQ-008 req_size_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned_i  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-010 req_wdata_i  input  32  store data, right-aligned.
REQ-011 rsp_valid_o  output  1  one-cycle response pulse; the consumer always accepts.
REQ-012 rsp_rdata_o  output  32  load result; 0 for stores and errors.
REQ-013 rsp_err_o  output  1  misaligned or illegal-size request.
REQ-014 ram_wen_o / ram_waddr_o / ram_wdata_o  output  1 / ADDR_BIT / 32  RAM write port.
REQ-015 ram_ren_o / ram_raddr_o  output  1 / ADDR_BIT  RAM read port.
REQ-016 ram_rdata_i  input  32  RAM read data, valid the cycle after ram_ren_o is high.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, MERGE and RESP; only one request is outstanding.
REQ-018 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i && req_ready_o, and all request fields are latched on that edge.
REQ-019 Error condition: size 11, halfword with addr[0]=1, or word with addr[1:0]!=0; IDLE goes to RESP with rsp_err_o=1 and rsp_rdata_o=0, and no RAM port is driven.
REQ-020 Otherwise IDLE goes to ACCESS.
REQ-021 ACCESS, word store: ram_wen_o=1, ram_waddr_o=word index, ram_wdata_o=latched data; next state RESP.
REQ-022 ACCESS, load or byte/half store: ram_ren_o=1, ram_raddr_o=word index; next state MERGE.
REQ-023 MERGE, load: capture the lane selected by addr[1:0] (byte) or addr[1] (half), extended per req_unsigned_i, into rsp_rdata_o; a word load is passed unmodified; next state RESP.
REQ-024 MERGE, sub-word store: ram_wen_o=1 and ram_wdata_o=ram_rdata_i, with the addressed byte lane replaced by wdata[7:0] or the half lane by wdata[15:0]; next state RESP.
REQ-025 RESP: rsp_valid_o=1 for exactly one cycle; next state IDLE.
REQ-026 Response latency from the acceptance edge T: error at T+1; word store at T+2; load and sub-word store at T+3.
REQ-027 ram_wen_o and ram_ren_o SHALL be 0 in every state and case not listed above, and SHALL never both be 1.
REQ-028 rsp_rdata_o and rsp_err_o SHALL hold their value until the next response is produced.
REQ-029 req_valid_i while req_ready_o=0 SHALL be ignored, with no latching.

Reset
REQ-030 While rst=1: state=IDLE, req_ready_o=0, and rsp_valid_o, rsp_err_o, rsp_rdata_o, ram_wen_o and ram_ren_o are all 0 immediately, without waiting for a clock edge.
REQ-031 Reset mid-operation SHALL abort the request with no response; a RAM write not yet issued SHALL NOT occur.
REQ-032 req_ready_o=1 from the first cycle after rst deasserts.

Verification
REQ-033 Word store, addr 0x10, data 0xDEADBEEF -> at T+1: ram_wen_o=1, waddr=4, wdata=0xDEADBEEF; at T+2: rsp_valid_o=1, err=0, rdata=0.
REQ-034 Word 4 holds 0xDEADBEEF; signed byte load at 0x13 -> rsp_rdata_o=0xFFFFFFDE at T+3; the same load unsigned -> 0x000000DE.
REQ-035 Halfword store of 0x1234 at 0x12 over 0xDEADBEEF -> at T+1: ren with raddr=4; at T+2: wen with wdata=0x1234BEEF; a following word load at 0x10 -> 0x1234BEEF.
REQ-036 Word load at 0x11, and size=11 at 0x10 -> each gives rsp_valid_o=1 with err=1 and rdata=0 at T+1; no ren or wen is ever seen.
REQ-037 req_valid_i held high with two loads queued -> ready=0 during ACCESS, MERGE and RESP; the second load is accepted at T+4; the responses are at T+3 and T+7.
REQ-038 rst pulsed during ACCESS of a byte store -> outputs go to 0 asynchronously, there is no response and no write, memory is unchanged, and ready=1 in the first cycle after release.
